// File: rtl/data_bus_bridge_pkg.sv
// Shared encodings for the core's data-side memory bridge: FSM states and
// access-size codes as they appear on data_size / rd_size / wr_size.
package data_bus_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/data_bus_bridge.sv
// Bridges the core's sram-like req/addr_ok/data_ok data port onto a split
// read/write valid-ready bus with a single outstanding transaction.
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_size,
  input  logic              rdresp_valid,
  input  logic [DATA_W-1:0] rdresp_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_size,
  output logic [3:0]        wr_strb,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wrresp_valid
);

  // Handshake rules: a bus request is transferred on the cycle valid&ready
  // are both high; valid rises only from a latched request and its payload
  // holds steady until that cycle. Responses have no ready (always taken).
  // The core side is transferred when data_req&data_addr_ok in IDLE.

  state_t            state;
  logic [1:0]        req_size;
  logic [3:0]        req_strb;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  assign data_addr_ok = (state == IDLE) & data_req;

  assign rd_addr = req_addr;
  assign rd_size = req_size;
  assign wr_addr = req_addr;
  assign wr_size = req_size;
  assign wr_strb = req_strb;
  assign wr_data = req_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_size     <= '0;
      req_strb     <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      rd_valid     <= 1'b0;
      wr_valid     <= 1'b0;
      data_data_ok <= 1'b0;
      data_rdata   <= '0;
    end else begin
      data_data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req) begin
            req_size  <= data_size;
            req_strb  <= data_wstrb;
            req_addr  <= data_addr;
            req_wdata <= data_wdata;
            if (data_wr) begin
              state    <= WR_REQ;
              wr_valid <= 1'b1;
            end else begin
              state    <= RD_REQ;
              rd_valid <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rdresp_valid) begin
            data_rdata   <= rdresp_data;
            data_data_ok <= 1'b1;
            state        <= IDLE;
          end
        end
        WR_REQ: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            state    <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          // Store completion leaves data_rdata holding the last load value.
          if (wrresp_valid) begin
            data_data_ok <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          rd_valid <= 1'b0;
          wr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
